// File: rtl/nand_rr_arbiter_if.sv
// rtl/nand_rr_arbiter_if.sv - request/grant/result bundle of the shared NAND evaluation unit
interface nand_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  a_in;
  logic [NREQ-1:0]  b_in;
  logic [NREQ-1:0]  gnt;
  logic             res;
  logic [ID_W-1:0]  res_id;
  logic             res_valid;
  logic             res_ack;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Arbiter side: consumes requests and the result acknowledge.
  modport slave (
    input  req, a_in, b_in, res_ack,
    output gnt, res, res_id, res_valid, busy, op_count
  );

  // Requester/consumer side.
  modport master (
    output req, a_in, b_in, res_ack,
    input  gnt, res, res_id, res_valid, busy, op_count
  );
endinterface

// File: rtl/nand_rr_arbiter.sv
// rtl/nand_rr_arbiter.sv - round-robin arbiter sharing one NAND evaluation unit among NREQ requesters
module nand_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  nand_rr_arbiter_if.slave  bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  sel_id_q;
  logic             a_lat_q;
  logic             b_lat_q;
  logic [NREQ-1:0]  gnt_q;
  logic             res_q;
  logic [ID_W-1:0]  res_id_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic             pick_vld_d;
  logic [ID_W-1:0]  pick_id_d;
  logic [ID_W-1:0]  cand;

  // Rotating priority: scan upward from ptr, the index wraps naturally because NREQ is a power of two.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_id_d  = ptr_q;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + ID_W'(i);
      if (!pick_vld_d && bus.req[cand]) begin
        pick_vld_d = 1'b1;
        pick_id_d  = cand;
      end
    end
  end

  // Control FSM: arbitration only in IDLE, operands latched at selection so later input changes cannot disturb the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_id_q    <= '0;
      a_lat_q     <= 1'b0;
      b_lat_q     <= 1'b0;
      gnt_q       <= '0;
      res_q       <= 1'b0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= '0;
          if (pick_vld_d) begin
            a_lat_q  <= bus.a_in[pick_id_d];
            b_lat_q  <= bus.b_in[pick_id_d];
            sel_id_q <= pick_id_d;
            gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= ~(a_lat_q & b_lat_q);
          res_id_q    <= sel_id_q;
          res_valid_q <= 1'b1;
          gnt_q       <= '0;
          op_count_q  <= op_count_q + CNT_W'(1);
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ack) begin
            res_valid_q <= 1'b0;
            ptr_q       <= res_id_q + ID_W'(1);
            state_q     <= IDLE;
          end
        end
        default: begin
          gnt_q       <= '0;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res       = res_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;
endmodule
